// File: rtl/btn_scan_pkg.sv
// Shared types, default parameters and helpers for the four-button select scanner.
package btn_scan_pkg;

  localparam int unsigned N_BTN         = 4;
  localparam int unsigned KEY_W         = 2;
  localparam int unsigned TICK_DIV_DEF  = 50000;
  localparam int unsigned DEB_TICKS_DEF = 10;

  typedef enum logic [1:0] {
    UP      = 2'd0,
    DB_DOWN = 2'd1,
    DOWN    = 2'd2,
    DB_UP   = 2'd3
  } deb_state_t;

  // Active-low one-cold code with only bit idx cleared.
  function automatic logic [N_BTN-1:0] one_cold(input logic [KEY_W-1:0] idx);
    return ~(N_BTN'(1) << idx);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Tick-driven debouncer for one synchronised button; raises pe for one cycle on an accepted press.
module btn_debounce
  import btn_scan_pkg::*;
#(
  parameter int unsigned DEB_TICKS = DEB_TICKS_DEF
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic tick,
  input  logic s,
  output logic held,
  output logic pe
);

  localparam int unsigned CW = $clog2(DEB_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_TICKS);

  deb_state_t    r_state;
  deb_state_t    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          r_held;
  logic          w_held_nxt;
  logic          r_pe;
  logic          w_pe_nxt;

  assign w_cnt_inc = r_cnt + CW'(1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= UP;
      r_cnt   <= '0;
      r_held  <= 1'b0;
      r_pe    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_held  <= w_held_nxt;
      r_pe    <= w_pe_nxt;
    end
  end

  // State only moves on a sample tick; pe is a single-cycle pulse on entry to DOWN.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pe_nxt    = 1'b0;
    if (tick) begin
      unique case (r_state)
        UP: begin
          if (s) begin
            if (DEB_TICKS == 1) begin
              w_state_nxt = DOWN;
              w_cnt_nxt   = '0;
              w_pe_nxt    = 1'b1;
            end else begin
              w_state_nxt = DB_DOWN;
              w_cnt_nxt   = CW'(1);
            end
          end
        end
        DB_DOWN: begin
          if (!s) begin
            w_state_nxt = UP;
            w_cnt_nxt   = '0;
          end else if (w_cnt_inc == CNT_LAST) begin
            w_state_nxt = DOWN;
            w_cnt_nxt   = '0;
            w_pe_nxt    = 1'b1;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
          end
        end
        DOWN: begin
          if (!s) begin
            if (DEB_TICKS == 1) begin
              w_state_nxt = UP;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = DB_UP;
              w_cnt_nxt   = CW'(1);
            end
          end
        end
        DB_UP: begin
          if (s) begin
            w_state_nxt = DOWN;
            w_cnt_nxt   = '0;
          end else if (w_cnt_inc == CNT_LAST) begin
            w_state_nxt = UP;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
          end
        end
        default: begin
          w_state_nxt = UP;
          w_cnt_nxt   = '0;
        end
      endcase
    end
    w_held_nxt = (w_state_nxt == DOWN) || (w_state_nxt == DB_UP);
  end

  assign held = r_held;
  assign pe   = r_pe;

endmodule

// File: rtl/btn_select_scan.sv
// Synchronises and debounces four active-low buttons and latches the lowest newly pressed one as a one-cold select.
module btn_select_scan
  import btn_scan_pkg::*;
#(
  parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
  parameter int unsigned DEB_TICKS = DEB_TICKS_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] sel,
  output logic [KEY_W-1:0] key_id,
  output logic             press,
  output logic [N_BTN-1:0] held
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;
  logic [N_BTN-1:0] w_s;
  logic [PW-1:0]    r_pre;
  logic             w_tick;
  logic [N_BTN-1:0] w_held;
  logic [N_BTN-1:0] w_pe;
  logic             w_any_pe;
  logic [KEY_W-1:0] w_k;
  logic [N_BTN-1:0] r_sel;
  logic [KEY_W-1:0] r_key_id;
  logic             r_press;

  // Two-flop synchroniser in pin polarity; idles high so reset looks like "released".
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = ~r_sync2;

  // Free-running sample prescaler.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  assign w_tick = (r_pre == PRE_LAST);

  for (genvar i = 0; i < N_BTN; i++) begin : g_deb
    btn_debounce #(
      .DEB_TICKS (DEB_TICKS)
    ) u_deb (
      .CLK   (CLK),
      .RST_N (RST_N),
      .tick  (w_tick),
      .s     (w_s[i]),
      .held  (w_held[i]),
      .pe    (w_pe[i])
    );
  end

  // Lowest-index press event wins.
  always_comb begin
    w_any_pe = |w_pe;
    w_k      = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (w_pe[i]) begin
        w_k = KEY_W'(i);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sel    <= one_cold(KEY_W'(0));
      r_key_id <= '0;
      r_press  <= 1'b0;
    end else if (w_any_pe) begin
      r_sel    <= one_cold(w_k);
      r_key_id <= w_k;
      r_press  <= 1'b1;
    end else begin
      r_press  <= 1'b0;
    end
  end

  assign sel    = r_sel;
  assign key_id = r_key_id;
  assign press  = r_press;
  assign held   = w_held;

endmodule

// File: tb/tb_btn_select_scan.sv
// Directed vector bench for btn_select_scan with TICK_DIV=4, DEB_TICKS=3.
module tb_btn_select_scan;

  logic       CLK;
  logic       RST_N;
  logic [3:0] btn;
  logic [3:0] sel;
  logic [1:0] key_id;
  logic       press;
  logic [3:0] held;

  int n_cmp;
  int n_fail;
  int n_press;
  logic prev_press;

  typedef struct {
    logic [3:0] btn;
    int         cycles;
    logic [3:0] sel;
    logic [1:0] key;
    logic [3:0] held;
    int         presses;
  } vec_t;

  vec_t tbl[15];

  btn_select_scan #(
    .TICK_DIV  (4),
    .DEB_TICKS (3)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .btn    (btn),
    .sel    (sel),
    .key_id (key_id),
    .press  (press),
    .held   (held)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded, required completion", $time);
    $fatal(1, "watchdog");
  end

  // Counts press pulses and flags any pulse wider than one cycle.
  initial prev_press = 1'b0;
  always @(negedge CLK) begin
    if (press === 1'b1) begin
      n_press++;
      n_cmp++;
      if (prev_press === 1'b1) begin
        n_fail++;
        $display("FAIL press_width: press high %0d consecutive cycles, required 1", 2);
      end
    end
    prev_press = press;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel"},    int'(sel),    int'(4'b1110));
    check({tag, "_key"},    int'(key_id), 0);
    check({tag, "_press"},  int'(press),  0);
    check({tag, "_held"},   int'(held),   0);
  endtask

  initial begin
    int base;
    n_cmp   = 0;
    n_fail  = 0;
    n_press = 0;

    //            btn      cyc  sel      key   held     presses
    tbl[0]  = '{4'b1111, 100, 4'b1110, 2'd0, 4'b0000, 0};
    tbl[1]  = '{4'b1011,  40, 4'b1011, 2'd2, 4'b0100, 1};
    tbl[2]  = '{4'b1111,  40, 4'b1011, 2'd2, 4'b0000, 0};
    tbl[3]  = '{4'b1101,   8, 4'b1011, 2'd2, 4'b0000, 0};
    tbl[4]  = '{4'b1111,  40, 4'b1011, 2'd2, 4'b0000, 0};
    tbl[5]  = '{4'b0101,  40, 4'b1101, 2'd1, 4'b1010, 1};
    tbl[6]  = '{4'b0111,  40, 4'b1101, 2'd1, 4'b1000, 0};
    tbl[7]  = '{4'b0101,  40, 4'b1101, 2'd1, 4'b1010, 1};
    tbl[8]  = '{4'b1111,  40, 4'b1101, 2'd1, 4'b0000, 0};
    tbl[9]  = '{4'b1101,  40, 4'b1101, 2'd1, 4'b0010, 1};
    tbl[10] = '{4'b1111,  40, 4'b1101, 2'd1, 4'b0000, 0};
    tbl[11] = '{4'b0111,  40, 4'b0111, 2'd3, 4'b1000, 1};
    tbl[12] = '{4'b1111,  40, 4'b0111, 2'd3, 4'b0000, 0};
    tbl[13] = '{4'b1101,  40, 4'b1101, 2'd1, 4'b0010, 1};
    tbl[14] = '{4'b1111,  40, 4'b1101, 2'd1, 4'b0000, 0};

    btn   = 4'b1111;
    RST_N = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");
    @(negedge CLK);
    RST_N = 1'b1;
    step();

    for (int v = 0; v < 15; v++) begin
      base = n_press;
      btn  = tbl[v].btn;
      repeat (tbl[v].cycles) step();
      check($sformatf("v%0d_sel", v),     int'(sel),    int'(tbl[v].sel));
      check($sformatf("v%0d_key", v),     int'(key_id), int'(tbl[v].key));
      check($sformatf("v%0d_held", v),    int'(held),   int'(tbl[v].held));
      check($sformatf("v%0d_presses", v), n_press - base, tbl[v].presses);
    end

    // Press button 3, reset while it is still debouncing, keep holding through release.
    base = n_press;
    btn  = 4'b0111;
    repeat (9) step();
    check("mid_db_held", int'(held), 0);
    RST_N = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (3) step();
    check_reset_outputs("mid_reset_hold");
    check("mid_no_press", n_press - base, 0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Edges counted from reset release: tick at edges 4,8,12 -> DOWN at 12, press at 13.
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c >= 11 && c <= 14) begin
        check($sformatf("rel_c%0d_press", c), int'(press), (c == 13) ? 1 : 0);
        check($sformatf("rel_c%0d_held", c),  int'(held),  (c >= 12) ? int'(4'b1000) : 0);
      end
      if (c == 13) begin
        check("rel_sel", int'(sel),    int'(4'b0111));
        check("rel_key", int'(key_id), 3);
      end
    end
    check("rel_presses", n_press - base, 1);

    btn = 4'b1111;
    repeat (40) step();
    check("final_held", int'(held), 0);
    check("final_sel",  int'(sel),  int'(4'b0111));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
